md5_block_loader: RTL and testbench
===================================

MD5_BLOCK_LOADER -- requirements
Module: md5_block_loader

Interface
REQ-001 SHALL have parameter CMD_LOAD, default 8'h01, command byte that opens a load frame.
REQ-002 SHALL have parameter MAX_LEN, default 55, largest message length in bytes accepted in one block.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rxd_data  input  8  received byte from the par8 receiver, valid only while rxd_data_ready=1.
REQ-006 SHALL have port rxd_data_ready  input  1  one-cycle strobe qualifying rxd_data.
REQ-007 SHALL have port block_out  output  512  padded MD5 message block; byte i at bits [8i+7:8i].
REQ-008 SHALL have port block_valid  output  1  block_out holds a complete block.
REQ-009 SHALL have port block_ready  input  1  consumer accepts block when block_valid=1 and block_ready=1 in the same cycle.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port err_pulse  output  1  one-cycle strobe on a protocol error.

Function
REQ-012 SHALL implement states IDLE, GET_LEN, GET_DATA, PAD, HOLD.
REQ-013 IDLE: on strobe with rxd_data==CMD_LOAD -> GET_LEN; on strobe with any other byte -> err_pulse=1, stay IDLE.
REQ-014 GET_LEN: on strobe, length N=rxd_data; N==0 or N>MAX_LEN -> err_pulse=1, IDLE; else byte counter=0, latch N, -> GET_DATA.
REQ-015 GET_DATA: each strobe writes rxd_data into block byte[counter], counter increments; strobe with counter==N-1 -> PAD.
REQ-016 PAD: one cycle, no strobe consumed; writes byte[N]=8'h80, bytes N+1..55=0, bytes 56..63 = 64-bit little-endian N*8; -> HOLD.
REQ-017 HOLD: block_valid=1; block_out stable; on block_ready=1 -> IDLE with block_valid=0 next cycle.
REQ-018 Latency: last data byte sampled at edge T; PAD active cycle T+1; block_valid=1 from cycle T+2.
REQ-019 block_ready asserted while block_valid=0 SHALL have no effect.
REQ-020 Strobes arriving in PAD or HOLD SHALL be discarded, pulse err_pulse=1, and not alter block_out or state.
REQ-021 Bytes 0..N-1 SHALL be freshly written every frame; no data from a prior frame appears in a new block.
REQ-022 Byte counter SHALL be 6 bits; length arithmetic N*8 SHALL be computed at 64-bit width with upper bytes zero.
REQ-023 err_pulse SHALL never be high two consecutive cycles unless two consecutive erroneous strobes occur.
REQ-024 busy SHALL equal (state != IDLE) combinationally from the state register.

Reset
REQ-025 On reset assertion, immediately: state=IDLE, block_valid=0, busy=0, err_pulse=0, block_out=0, counter=0, N=0.
REQ-026 Reset mid-frame (any state) SHALL abandon the frame; the next frame requires a fresh CMD_LOAD.
REQ-027 First strobe after reset release SHALL be evaluated in IDLE.

Verification
REQ-028 Strobes 01,03,61,62,63 -> block_valid at T+2; byte0..3=61,62,63,80; byte56=18; all other bytes 00; held until block_ready.
REQ-029 Strobes 01,37 then 55 bytes 00..36 -> byte54=36, byte55=80, byte56=B8, byte57=01, bytes 58..63=00.
REQ-030 Strobes 01,00 and separately 01,38 -> err_pulse one cycle each, block_valid stays 0, busy returns 0.
REQ-031 Strobe 7F in IDLE -> err_pulse one cycle, state IDLE; then 01,01,AA -> byte0=AA, byte1=80, byte56=08.
REQ-032 Block held with block_ready=0 for 20 cycles plus strobe 55 injected -> block_out unchanged, err_pulse once; block_ready=1 -> IDLE next cycle.
REQ-033 Reset asserted after 01,05,11,22 -> all outputs 0 asynchronously; after release, strobes 05,... -> err_pulse (not CMD_LOAD).

Source files
------------

// File: rtl/md5_block_loader.sv
// Assembles one padded 512-bit MD5 block from a byte stream: CMD_LOAD, length N, N data bytes.
// Padding (0x80, zero fill, 64-bit little-endian bit length) is applied in a single cycle.
module md5_block_loader #(
    parameter logic [7:0] CMD_LOAD = 8'h01,
    parameter int         MAX_LEN  = 55
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rxd_data,
    input  logic         rxd_data_ready,
    output logic [511:0] block_out,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         busy,
    output logic         err_pulse
);

    // state    | meaning
    // IDLE     | waiting for CMD_LOAD
    // GET_LEN  | next strobe is the message length N
    // GET_DATA | collecting N message bytes into block_out
    // PAD      | one cycle: write 0x80, zero fill and bit length
    // HOLD     | block_valid high until block_ready
    typedef enum logic [2:0] {IDLE, GET_LEN, GET_DATA, PAD, HOLD} state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t       state, state_next;
    logic [5:0]   cnt;
    logic [5:0]   len;
    logic         err_next;
    logic         load_len;
    logic         wr_byte;
    logic         do_pad;
    logic [63:0]  len_bits;
    logic [511:0] pad_block;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        load_len   = 1'b0;
        wr_byte    = 1'b0;
        do_pad     = 1'b0;
        case (state)
            IDLE: begin
                if (rxd_data_ready) begin
                    if (rxd_data == CMD_LOAD) state_next = GET_LEN;
                    else                      err_next   = 1'b1;
                end
            end
            GET_LEN: begin
                if (rxd_data_ready) begin
                    if (rxd_data == 8'd0 || rxd_data > MAX_LEN_B) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        load_len   = 1'b1;
                        state_next = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (rxd_data_ready) begin
                    wr_byte = 1'b1;
                    if (cnt == len - 6'd1) state_next = PAD;
                end
            end
            PAD: begin
                do_pad     = 1'b1;
                err_next   = rxd_data_ready;
                state_next = HOLD;
            end
            HOLD: begin
                err_next = rxd_data_ready;
                if (block_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign block_valid = (state == HOLD);
    assign len_bits    = {55'd0, len, 3'b000};

    // Bytes below N keep the data just written; everything above is rebuilt so no stale bytes survive.
    always_comb begin
        pad_block = block_out;
        for (int i = 0; i < 56; i++) begin
            if (i == int'(len))
                pad_block[8*i +: 8] = 8'h80;
            else if (i > int'(len))
                pad_block[8*i +: 8] = 8'h00;
        end
        for (int k = 0; k < 8; k++)
            pad_block[8*(56+k) +: 8] = len_bits[8*k +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            block_out <= '0;
            cnt       <= '0;
            len       <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_next;
            if (load_len) begin
                len <= rxd_data[5:0];
                cnt <= '0;
            end
            if (wr_byte) begin
                block_out[{cnt, 3'b000} +: 8] <= rxd_data;
                cnt                           <= cnt + 6'd1;
            end
            if (do_pad) block_out <= pad_block;
        end
    end

endmodule

// File: tb/tb_md5_block_loader.sv
// Self-checking bench for md5_block_loader: directed scenarios plus random frames
// compared against a byte-array padding model.
module tb_md5_block_loader;

    logic         clk;
    logic         reset;
    logic [7:0]   rxd_data;
    logic         rxd_data_ready;
    logic [511:0] block_out;
    logic         block_valid;
    logic         block_ready;
    logic         busy;
    logic         err_pulse;

    int errors = 0;
    int checks = 0;

    logic [7:0] frame [64];

    md5_block_loader dut (
        .clk            (clk),
        .reset          (reset),
        .rxd_data       (rxd_data),
        .rxd_data_ready (rxd_data_ready),
        .block_out      (block_out),
        .block_valid    (block_valid),
        .block_ready    (block_ready),
        .busy           (busy),
        .err_pulse      (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MD5 padding of an n-byte message held in frame[]
    function automatic logic [511:0] model_block(input int n);
        logic [7:0]  b [64];
        logic [63:0] bitlen;
        logic [511:0] r;
        bitlen = 64'(n) * 64'd8;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < n; i++) b[i] = frame[i];
        b[n] = 8'h80;
        for (int k = 0; k < 8; k++) b[56+k] = 8'((bitlen >> (8*k)) & 64'hFF);
        r = '0;
        for (int i = 0; i < 64; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    task automatic strobe(input logic [7:0] b, output logic err);
        @(negedge clk);
        rxd_data       = b;
        rxd_data_ready = 1'b1;
        @(posedge clk);
        #1;
        err            = err_pulse;
        rxd_data_ready = 1'b0;
    endtask

    task automatic load_and_check(input string tag, input int n);
        logic e;
        logic [511:0] exp_blk;
        exp_blk = model_block(n);
        strobe(8'h01, e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL %s_cmd_err got=%b exp=0", tag, e); end
        strobe(8'(n), e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL %s_len_err got=%b exp=0", tag, e); end
        for (int i = 0; i < n; i++) strobe(frame[i], e);
        checks++; if (block_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL %s_pad_cycle got valid=%b busy=%b exp valid=0 busy=1", tag, block_valid, busy);
        end
        @(posedge clk); #1;
        checks++; if (block_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got=%b exp=1", tag, block_valid); end
        checks++; if (block_out !== exp_blk) begin
            errors++; $display("FAIL %s_block got=%h exp=%h", tag, block_out, exp_blk);
        end
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        block_ready = 1'b1;
        @(posedge clk); #1;
        block_ready = 1'b0;
        checks++; if (block_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_accept got valid=%b busy=%b exp 0 0", tag, block_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rxd_data = 8'h00; rxd_data_ready = 1'b0; block_ready = 1'b0;
        #2;
        checks++; if ({block_valid, busy, err_pulse} !== 3'b000 || block_out !== '0) begin
            errors++; $display("FAIL reset_outputs got valid=%b busy=%b err=%b blk=%h exp all 0", block_valid, busy, err_pulse, block_out);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        block_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (block_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ready_when_idle got valid=%b busy=%b exp 0 0", block_valid, busy);
        end
        @(negedge clk); block_ready = 1'b0;
    endtask

    task automatic test_short_frame();
        frame[0] = 8'h61; frame[1] = 8'h62; frame[2] = 8'h63;
        load_and_check("short", 3);
        checks++; if (block_out[8*56 +: 8] !== 8'h18 || block_out[8*3 +: 8] !== 8'h80) begin
            errors++; $display("FAIL short_bytes got b3=%h b56=%h exp 80 18", block_out[8*3 +: 8], block_out[8*56 +: 8]);
        end
        repeat (3) @(posedge clk); #1;
        checks++; if (block_valid !== 1'b1) begin errors++; $display("FAIL short_held got=%b exp=1", block_valid); end
        accept("short");
    endtask

    task automatic test_max_frame();
        for (int i = 0; i < 55; i++) frame[i] = 8'(i);
        load_and_check("max", 55);
        checks++; if (block_out[511:8*54] !== {64'h0000_0000_0000_01B8, 8'h80, 8'h36}) begin
            errors++; $display("FAIL max_tail got=%h exp=00000000000001b88036", block_out[511:8*54]);
        end
        accept("max");
    endtask

    task automatic test_len_errors();
        logic e;
        logic [7:0] bad [2];
        bad[0] = 8'h00; bad[1] = 8'h38;
        for (int k = 0; k < 2; k++) begin
            strobe(8'h01, e);
            strobe(bad[k], e);
            checks++; if (e !== 1'b1 || block_valid !== 1'b0) begin
                errors++; $display("FAIL len_err_%0d got err=%b valid=%b exp 1 0", k, e, block_valid);
            end
            @(posedge clk); #1;
            checks++; if (err_pulse !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL len_err_after_%0d got err=%b busy=%b exp 0 0", k, err_pulse, busy);
            end
        end
    endtask

    task automatic test_bad_cmd();
        logic e;
        strobe(8'h7F, e);
        checks++; if (e !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bad_cmd got err=%b busy=%b exp 1 0", e, busy);
        end
        @(posedge clk); #1;
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL bad_cmd_once got=%b exp=0", err_pulse); end
        frame[0] = 8'hAA;
        load_and_check("one", 1);
        accept("one");
    endtask

    task automatic test_hold();
        logic [511:0] held;
        int err_cnt;
        for (int i = 0; i < 10; i++) frame[i] = 8'($urandom);
        load_and_check("hold", 10);
        held = block_out;
        err_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rxd_data       = 8'h55;
            rxd_data_ready = (c == 7);
            @(posedge clk); #1;
            if (err_pulse === 1'b1) err_cnt++;
            rxd_data_ready = 1'b0;
        end
        checks++; if (block_out !== held || block_valid !== 1'b1) begin
            errors++; $display("FAIL hold_stable got valid=%b blk=%h exp valid=1 blk=%h", block_valid, block_out, held);
        end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL hold_err_count got=%0d exp=1", err_cnt); end
        accept("hold");
    endtask

    task automatic test_mid_reset();
        logic e;
        strobe(8'h01, e); strobe(8'h05, e); strobe(8'h11, e); strobe(8'h22, e);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got=%b exp=1", busy); end
        reset = 1'b1;
        #1;
        checks++; if ({block_valid, busy, err_pulse} !== 3'b000 || block_out !== '0) begin
            errors++; $display("FAIL midrst_async got valid=%b busy=%b err=%b blk=%h exp all 0", block_valid, busy, err_pulse, block_out);
        end
        @(negedge clk); reset = 1'b0;
        strobe(8'h05, e);
        checks++; if (e !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_fresh got err=%b busy=%b exp 1 0", e, busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int f = 0; f < 12; f++) begin
            n = (f == 0) ? 55 : int'($urandom_range(1, 55));
            for (int i = 0; i < n; i++) frame[i] = 8'($urandom);
            load_and_check($sformatf("rnd%0d", f), n);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            accept($sformatf("rnd%0d", f));
        end
    endtask

    task automatic test_random_bad_len();
        logic e;
        logic [7:0] l;
        for (int k = 0; k < 5; k++) begin
            l = 8'($urandom_range(56, 255));
            strobe(8'h01, e);
            strobe(l, e);
            checks++; if (e !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL rnd_bad_len_%h got err=%b busy=%b exp 1 0", l, e, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_frame();
        test_max_frame();
        test_len_errors();
        test_bad_cmd();
        test_hold();
        test_mid_reset();
        test_back_to_back();
        test_random_bad_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
